adc_burst_sequencer: RTL and testbench

Multi-channel acquisition sequencer between the ultrasonic burst logic and the per-ADC SPI master / sample FIFO. On a start pulse it runs one capture burst of BURST_LEN frames. Each frame is launched by a programmable sample tick and converts every enabled ADC channel in ascending order through one SPI_MASTER_DEVICE. Each result is written to the FIFO as a channel-tagged word, with overrun and missed-tick detection.

---
 rtl/adc_burst_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_adc_burst_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_burst_sequencer.sv
// adc_burst_sequencer
// Runs one capture burst of BURST_LEN frames after a start pulse. A
// free-running tick counter (period SAMPLE_DIV) launches each frame. Every
// enabled channel is then converted in ascending order through the SPI master.
// Each result is written to the FIFO with its channel number in the top bits.
//
// Ports:
//   CLK_40, rst          clock and synchronous active-high reset
//   start, stop          one-cycle control pulses
//   chan_mask            channel enables, latched when a burst starts
//   spi_ena, spi_cmd     request and command word to the SPI master
//   spi_fin, spi_data    completion pulse and returned data from the SPI master
//   fifo_full            FIFO full flag
//   fifo_wr, fifo_din    FIFO write strobe and tagged sample
//   busy, done           burst in progress, end-of-burst pulse
//   overrun, missed_tick sticky error flags, cleared by the next accepted start
//   frame_cnt            frames completed in the current or last burst
//
// Optional build macro:
//   ADC_SEQ_OVERRUN_STOP_EN  when defined, the first sample dropped on a full
//                            FIFO ends the burst at that STORE.
`timescale 1ns/1ps
module adc_burst_sequencer #(
    parameter int NUM_CH     = 4,
    parameter int SAMPLE_DIV = 128,
    parameter int BURST_LEN  = 4096
) (
    input  logic              CLK_40,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_CH-1:0] chan_mask,
    output logic              spi_ena,
    output logic [15:0]       spi_cmd,
    input  logic              spi_fin,
    input  logic [15:0]       spi_data,
    input  logic              fifo_full,
    output logic              fifo_wr,
    output logic [15:0]       fifo_din,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic              missed_tick,
    output logic [19:0]       frame_cnt
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    typedef enum logic [2:0] {IDLE, WAIT_TICK, CONVERT, STORE, DONE} state_t;

    state_t              state_q, state_d;
    logic [TW-1:0]       tickCnt_q, tickCnt_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [1:0]          chPtr_q, chPtr_d;
    logic [15:0]         word_q, word_d;
    logic [19:0]         frameCnt_q, frameCnt_d;
    logic                overrun_q, overrun_d;
    logic                missed_q, missed_d;
    logic                stopPend_q, stopPend_d;

    logic                tickHit;
    logic                busyInt;
    logic [1:0]          firstCh;
    logic [1:0]          nextCh;
    logic                hasNext;
    logic                unusedSpiBits;

    // Only the 12-bit conversion result is forwarded.
    assign unusedSpiBits = ^spi_data[15:12];

    assign tickHit = (tickCnt_q == TW'(SAMPLE_DIV - 1));
    assign busyInt = (state_q == WAIT_TICK) || (state_q == CONVERT) || (state_q == STORE);

    // Lowest enabled channel, and the lowest enabled channel above the current one.
    // The loops run downwards, so the last match found is the lowest index.
    always_comb begin
        firstCh = 2'd0;
        nextCh  = 2'd0;
        hasNext = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                firstCh = 2'(i);
                if (i > int'(chPtr_q)) begin
                    nextCh  = 2'(i);
                    hasNext = 1'b1;
                end
            end
        end
    end

    // Next-state and output logic. A stop seen while waiting for a tick ends the
    // burst at once. A stop raised during a conversion, or given together with
    // start, is held pending until the next STORE has finished.
    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tickCnt_q;
        mask_d     = mask_q;
        chPtr_d    = chPtr_q;
        word_d     = word_q;
        frameCnt_d = frameCnt_q;
        overrun_d  = overrun_q;
        missed_d   = missed_q;
        stopPend_d = stopPend_q;
        spi_ena    = 1'b0;
        spi_cmd    = 16'h0000;
        fifo_wr    = 1'b0;
        done       = 1'b0;

        if (busyInt) begin
            tickCnt_d = tickHit ? '0 : tickCnt_q + 1'b1;
            if (stop) begin
                stopPend_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start && (|chan_mask)) begin
                    mask_d     = chan_mask;
                    frameCnt_d = 20'd0;
                    overrun_d  = 1'b0;
                    missed_d   = 1'b0;
                    tickCnt_d  = '0;
                    stopPend_d = stop;
                    state_d    = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (stop) begin
                    state_d = DONE;
                end else if (tickHit) begin
                    chPtr_d = firstCh;
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                spi_ena = 1'b1;
                spi_cmd = {4'b0001, 1'b1, 2'b00, chPtr_q, 7'b1000000};
                if (tickHit) begin
                    missed_d = 1'b1;
                end
                if (spi_fin) begin
                    word_d  = {chPtr_q, 2'b00, spi_data[11:0]};
                    state_d = STORE;
                end
            end
            STORE: begin
                if (tickHit) begin
                    missed_d = 1'b1;
                end
                if (!fifo_full) begin
                    fifo_wr = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
                if (!hasNext) begin
                    frameCnt_d = frameCnt_q + 20'd1;
                end
                if (stopPend_q || stop) begin
                    state_d = DONE;
                end
`ifdef ADC_SEQ_OVERRUN_STOP_EN
                else if (fifo_full) begin
                    state_d = DONE;
                end
`endif
                else if (hasNext) begin
                    chPtr_d = nextCh;
                    state_d = CONVERT;
                end else if ((frameCnt_q + 20'd1) == 20'(BURST_LEN)) begin
                    state_d = DONE;
                end else begin
                    state_d = WAIT_TICK;
                end
            end
            DONE: begin
                done       = 1'b1;
                stopPend_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK_40) begin
        if (rst) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            mask_q     <= '0;
            chPtr_q    <= 2'd0;
            word_q     <= 16'h0000;
            frameCnt_q <= 20'd0;
            overrun_q  <= 1'b0;
            missed_q   <= 1'b0;
            stopPend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tickCnt_q  <= tickCnt_d;
            mask_q     <= mask_d;
            chPtr_q    <= chPtr_d;
            word_q     <= word_d;
            frameCnt_q <= frameCnt_d;
            overrun_q  <= overrun_d;
            missed_q   <= missed_d;
            stopPend_q <= stopPend_d;
        end
    end

    assign busy        = busyInt;
    assign fifo_din    = word_q;
    assign overrun     = overrun_q;
    assign missed_tick = missed_q;
    assign frame_cnt   = frameCnt_q;

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Testbench for adc_burst_sequencer (NUM_CH=4, SAMPLE_DIV=128, BURST_LEN=3).
// The stimulus pushes the expected FIFO words and SPI commands into queues.
// A monitor pops and compares them whenever the DUT writes or starts a
// transfer. The SPI master model answers after spiLat cycles with a fixed
// per-channel value.
`timescale 1ns/1ps
module tb_adc_burst_sequencer;

    logic        CLK_40 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [3:0]  chan_mask = 4'b0000;
    logic        spi_ena;
    logic [15:0] spi_cmd;
    logic        spi_fin = 1'b0;
    logic [15:0] spi_data = 16'h0000;
    logic        fifo_full = 1'b0;
    logic        fifo_wr;
    logic [15:0] fifo_din;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        missed_tick;
    logic [19:0] frame_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    int          cycle = 0;
    int          wrCnt = 0;
    int          spiLat = 3;
    logic [15:0] expQ[$];
    logic [15:0] cmdQ[$];
    int          riseQ[$];
    logic [15:0] respData[4];

    adc_burst_sequencer #(.NUM_CH(4), .SAMPLE_DIV(128), .BURST_LEN(3)) dut (
        .CLK_40(CLK_40), .rst(rst), .start(start), .stop(stop), .chan_mask(chan_mask),
        .spi_ena(spi_ena), .spi_cmd(spi_cmd), .spi_fin(spi_fin), .spi_data(spi_data),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_din(fifo_din), .busy(busy),
        .done(done), .overrun(overrun), .missed_tick(missed_tick), .frame_cnt(frame_cnt)
    );

    always #5 CLK_40 = ~CLK_40;

    always @(posedge CLK_40) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // SPI master model: answers each request after spiLat enabled cycles.
    initial begin
        int  cnt;
        logic given;
        cnt   = 0;
        given = 1'b0;
        respData[0] = 16'h0ABC;
        respData[1] = 16'hF123;
        respData[2] = 16'h0456;
        respData[3] = 16'h5789;
        forever begin
            @(negedge CLK_40);
            spi_fin = 1'b0;
            if (spi_ena && !given) begin
                cnt++;
                if (cnt >= spiLat) begin
                    spi_fin  = 1'b1;
                    spi_data = respData[spi_cmd[8:7]];
                    given    = 1'b1;
                end
            end else if (!spi_ena) begin
                cnt   = 0;
                given = 1'b0;
            end
        end
    end

    // Monitor: scoreboard for FIFO words and SPI commands.
    initial begin
        logic prevEna;
        logic [15:0] e;
        prevEna = 1'b0;
        forever begin
            @(negedge CLK_40);
            if (fifo_wr) begin
                wrCnt++;
                if (expQ.size() == 0) begin
                    checkOutput("fifo_unexpected_write", 32'(fifo_din), 32'hFFFFFFFF);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("fifo_din", 32'(fifo_din), 32'(e));
                end
            end
            if (spi_ena && !prevEna) begin
                if (spi_cmd == 16'h1840) riseQ.push_back(cycle);
                if (cmdQ.size() == 0) begin
                    checkOutput("spi_cmd_unexpected", 32'(spi_cmd), 32'hFFFFFFFF);
                end else begin
                    e = cmdQ.pop_front();
                    checkOutput("spi_cmd", 32'(spi_cmd), 32'(e));
                end
            end
            prevEna = spi_ena;
        end
    end

    task automatic applyStimulus(input logic [3:0] mask, input logic withStop);
        chan_mask = mask;
        start     = 1'b1;
        stop      = withStop;
        @(posedge CLK_40); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget, output int doneSeen);
        doneSeen = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge CLK_40);
            if (done) doneSeen++;
            if (doneSeen != 0 && !done) break;
        end
        checkOutput(name, 32'(doneSeen), 32'd1);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_spi_ena"}, 32'(spi_ena), 32'd0);
        checkOutput({tag, "_spi_cmd"}, 32'(spi_cmd), 32'd0);
        checkOutput({tag, "_fifo_wr"}, 32'(fifo_wr), 32'd0);
        checkOutput({tag, "_fifo_din"}, 32'(fifo_din), 32'd0);
        checkOutput({tag, "_overrun"}, 32'(overrun), 32'd0);
        checkOutput({tag, "_missed_tick"}, 32'(missed_tick), 32'd0);
        checkOutput({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    task automatic checkSpacing(input string name, input int n, input int gap);
        checkOutput({name, "_count"}, 32'(riseQ.size()), 32'(n));
        for (int i = 1; i < riseQ.size(); i++) begin
            checkOutput(name, 32'(riseQ[i] - riseQ[i-1]), 32'(gap));
        end
        riseQ.delete();
    endtask

    initial begin
        int d;
        int w0;
        int frames;
        logic prev;

        // Reset state.
        repeat (3) @(posedge CLK_40);
        #1;
        checkIdleOutputs("reset");
        rst = 1'b0;
        @(posedge CLK_40); #1;

        // Single channel, three frames one tick apart.
        w0 = wrCnt;
        riseQ.delete();
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(16'h0ABC);
            cmdQ.push_back(16'h1840);
        end
        applyStimulus(4'b0001, 1'b0);
        checkOutput("single_busy", 32'(busy), 32'd1);
        waitDone("single_done", 1000, d);
        checkOutput("single_writes", 32'(wrCnt - w0), 32'd3);
        checkOutput("single_frame_cnt", 32'(frame_cnt), 32'd3);
        checkOutput("single_missed", 32'(missed_tick), 32'd0);
        checkSpacing("single_tick_gap", 3, 128);

        // Channels 1 and 3.
        w0 = wrCnt;
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(16'h4123);
            expQ.push_back(16'hC789);
            cmdQ.push_back(16'h18C0);
            cmdQ.push_back(16'h19C0);
        end
        applyStimulus(4'b1010, 1'b0);
        waitDone("multi_done", 1000, d);
        checkOutput("multi_writes", 32'(wrCnt - w0), 32'd6);
        checkOutput("multi_frame_cnt", 32'(frame_cnt), 32'd3);

        // FIFO full from the second frame onwards.
        w0 = wrCnt;
        expQ.push_back(16'h0ABC);
`ifdef ADC_SEQ_OVERRUN_STOP_EN
        frames = 2;
`else
        frames = 3;
`endif
        for (int i = 0; i < frames; i++) cmdQ.push_back(16'h1840);
        applyStimulus(4'b0001, 1'b0);
        d = 0;
        for (int n = 0; n < 400 && !fifo_wr; n++) @(negedge CLK_40);
        checkOutput("overrun_first_write", 32'(fifo_wr), 32'd1);
        @(posedge CLK_40); #1;
        fifo_full = 1'b1;
        waitDone("overrun_done", 1000, d);
        checkOutput("overrun_flag", 32'(overrun), 32'd1);
        checkOutput("overrun_writes", 32'(wrCnt - w0), 32'd1);
        checkOutput("overrun_frame_cnt", 32'(frame_cnt), 32'(frames));
        fifo_full = 1'b0;

        // Four slow channels overrun the frame period, so one tick is lost each frame.
        w0 = wrCnt;
        spiLat = 40;
        riseQ.delete();
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(16'h0ABC);
            expQ.push_back(16'h4123);
            expQ.push_back(16'h8456);
            expQ.push_back(16'hC789);
            cmdQ.push_back(16'h1840);
            cmdQ.push_back(16'h18C0);
            cmdQ.push_back(16'h1940);
            cmdQ.push_back(16'h19C0);
        end
        applyStimulus(4'b1111, 1'b0);
        checkOutput("missed_cleared_on_start", 32'(overrun), 32'd0);
        waitDone("missed_done", 2000, d);
        checkOutput("missed_flag", 32'(missed_tick), 32'd1);
        checkOutput("missed_frame_cnt", 32'(frame_cnt), 32'd3);
        checkOutput("missed_writes", 32'(wrCnt - w0), 32'd12);
        checkSpacing("missed_tick_gap", 3, 256);

        // Reset during a conversion.
        w0 = wrCnt;
        cmdQ.push_back(16'h1840);
        applyStimulus(4'b0001, 1'b0);
        for (int n = 0; n < 400 && !spi_ena; n++) @(negedge CLK_40);
        checkOutput("rst_mid_ena_seen", 32'(spi_ena), 32'd1);
        rst = 1'b1;
        @(posedge CLK_40); #1;
        checkIdleOutputs("rst_mid");
        rst = 1'b0;
        repeat (5) @(posedge CLK_40);
        #1;
        checkOutput("rst_mid_no_write", 32'(wrCnt - w0), 32'd0);
        spiLat = 3;
        riseQ.delete();
        for (int i = 0; i < 3; i++) begin
            expQ.push_back(16'h0ABC);
            cmdQ.push_back(16'h1840);
        end
        applyStimulus(4'b0001, 1'b0);
        waitDone("after_rst_done", 1000, d);
        checkOutput("after_rst_writes", 32'(wrCnt - w0), 32'd3);
        checkOutput("after_rst_frame_cnt", 32'(frame_cnt), 32'd3);
        riseQ.delete();

        // Stop during the second frame's conversion.
        w0 = wrCnt;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(16'h0ABC);
            cmdQ.push_back(16'h1840);
        end
        applyStimulus(4'b0001, 1'b0);
        prev = 1'b0;
        d = 0;
        for (int n = 0; n < 600 && d < 2; n++) begin
            @(negedge CLK_40);
            if (spi_ena && !prev) d++;
            prev = spi_ena;
        end
        checkOutput("stop_second_frame_seen", 32'(d), 32'd2);
        stop = 1'b1;
        @(posedge CLK_40); #1;
        stop = 1'b0;
        waitDone("stop_done", 400, d);
        checkOutput("stop_frame_cnt", 32'(frame_cnt), 32'd2);
        checkOutput("stop_writes", 32'(wrCnt - w0), 32'd2);

        // Start and stop together: exactly one frame.
        w0 = wrCnt;
        expQ.push_back(16'h0ABC);
        cmdQ.push_back(16'h1840);
        applyStimulus(4'b0001, 1'b1);
        waitDone("startstop_done", 400, d);
        checkOutput("startstop_frame_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("startstop_writes", 32'(wrCnt - w0), 32'd1);

        // Start with an empty mask is ignored, and frame_cnt keeps its last value.
        applyStimulus(4'b0000, 1'b0);
        checkOutput("bad_start_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge CLK_40);
        #1;
        checkOutput("bad_start_busy_later", 32'(busy), 32'd0);
        checkOutput("bad_start_frame_cnt", 32'(frame_cnt), 32'd1);

        checkOutput("fifo_queue_empty", 32'(expQ.size()), 32'd0);
        checkOutput("cmd_queue_empty", 32'(cmdQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
